// File: rtl/set_assoc_cache_level.sv
// N-way set-associative write-back cache level with true LRU replacement,
// dirty tracking and flush-invalidate. Misses go to the next level over a
// req/ack handshake; one request is in flight at a time.
module set_assoc_cache_level #(
    parameter int CACHE_TAG_WIDTH  = 4,
    parameter int CACHE_DATA_WIDTH = 4,
    parameter int OPCODE_WIDTH     = 2,
    parameter int SETS             = 4,
    parameter int WAYS             = 2
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [OPCODE_WIDTH+CACHE_TAG_WIDTH+CACHE_DATA_WIDTH-1:0] vector_in,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    output logic [CACHE_DATA_WIDTH-1:0]                        data_out,
    output logic                                               hit_miss_out,
    output logic                                               out_valid,
    output logic                                               mem_req,
    output logic                                               mem_we,
    output logic [CACHE_TAG_WIDTH-1:0]                         mem_addr,
    output logic [CACHE_DATA_WIDTH-1:0]                        mem_wdata,
    input  logic                                               mem_ack,
    input  logic [CACHE_DATA_WIDTH-1:0]                        mem_rdata
);
    localparam int SET_BITS = $clog2(SETS);
    localparam int AGE_BITS = $clog2(WAYS);
    localparam int TAG_BITS = CACHE_TAG_WIDTH - SET_BITS;
    localparam int VEC_W    = OPCODE_WIDTH + CACHE_TAG_WIDTH + CACHE_DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;
    typedef enum logic [1:0] {OP_NOP, OP_READ, OP_WRITE, OP_FLUSH} op_t;

    state_t state, state_next;

    // Per-way line state
    logic                        line_valid [SETS][WAYS];
    logic                        line_dirty [SETS][WAYS];
    logic [TAG_BITS-1:0]         line_tag   [SETS][WAYS];
    logic [CACHE_DATA_WIDTH-1:0] line_data  [SETS][WAYS];
    logic [AGE_BITS-1:0]         line_age   [SETS][WAYS];

    // Captured request and response bookkeeping
    op_t                         req_op;
    logic [CACHE_TAG_WIDTH-1:0]  req_addr;
    logic [CACHE_DATA_WIDTH-1:0] req_wdata;
    logic [AGE_BITS-1:0]         sel_way;
    logic                        sel_hit;
    logic [CACHE_DATA_WIDTH-1:0] resp_data;

    op_t                         in_op;
    logic [SET_BITS-1:0]         req_set;
    logic [TAG_BITS-1:0]         req_tag;

    // Lookup results for the captured request
    logic                        lk_hit, has_inv;
    logic [AGE_BITS-1:0]         hit_way, inv_way, lru_way, lk_way;
    logic                        lk_dirty, needs_wb;
    logic [CACHE_DATA_WIDTH-1:0] lk_data;

    assign in_op    = op_t'(vector_in[VEC_W-1 -: OPCODE_WIDTH]);
    assign req_set  = req_addr[SET_BITS-1:0];
    assign req_tag  = req_addr[CACHE_TAG_WIDTH-1:SET_BITS];
    assign in_ready = (state == IDLE);

    // Tag match, victim choice (lowest invalid way, else the oldest way)
    always_comb begin
        lk_hit  = 1'b0;
        has_inv = 1'b0;
        hit_way = '0;
        inv_way = '0;
        lru_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (line_valid[req_set][AGE_BITS'(w)] && line_tag[req_set][AGE_BITS'(w)] == req_tag) begin
                lk_hit  = 1'b1;
                hit_way = AGE_BITS'(w);
            end
            if (!line_valid[req_set][AGE_BITS'(w)] && !has_inv) begin
                has_inv = 1'b1;
                inv_way = AGE_BITS'(w);
            end
            if (line_age[req_set][AGE_BITS'(w)] == AGE_BITS'(WAYS - 1))
                lru_way = AGE_BITS'(w);
        end
        lk_way   = lk_hit ? hit_way : (has_inv ? inv_way : lru_way);
        lk_dirty = line_valid[req_set][lk_way] && line_dirty[req_set][lk_way];
        lk_data  = line_data[req_set][lk_way];
        // a dirty hit is written back only when flushing; a dirty victim only when allocating
        needs_wb = lk_dirty && (lk_hit ? (req_op == OP_FLUSH) : (req_op != OP_FLUSH));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (in_valid && in_op != OP_NOP) state_next = LOOKUP;
            LOOKUP: begin
                if (needs_wb)                          state_next = WRITEBACK;
                else if (!lk_hit && req_op == OP_READ) state_next = FILL;
                else                                   state_next = RESPOND;
            end
            WRITEBACK: if (mem_ack) state_next = (req_op == OP_READ) ? FILL : RESPOND;
            FILL:      if (mem_ack) state_next = RESPOND;
            RESPOND:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Request capture, next-level handshake outputs and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_op       <= OP_NOP;
            req_addr     <= '0;
            req_wdata    <= '0;
            sel_way      <= '0;
            sel_hit      <= 1'b0;
            resp_data    <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            out_valid    <= 1'b0;
            hit_miss_out <= 1'b0;
            data_out     <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        req_op    <= in_op;
                        req_addr  <= vector_in[CACHE_TAG_WIDTH+CACHE_DATA_WIDTH-1:CACHE_DATA_WIDTH];
                        req_wdata <= vector_in[CACHE_DATA_WIDTH-1:0];
                    end
                end
                LOOKUP: begin
                    sel_way   <= lk_way;
                    sel_hit   <= lk_hit;
                    // read misses overwrite this with the fill data
                    resp_data <= (req_op == OP_WRITE) ? req_wdata : (lk_hit ? lk_data : '0);
                    if (state_next == WRITEBACK) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= lk_hit ? req_addr : {line_tag[req_set][lk_way], req_set};
                        mem_wdata <= lk_data;
                    end else if (state_next == FILL) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= req_addr;
                        mem_wdata <= '0;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        if (req_op == OP_READ) begin
                            mem_we    <= 1'b0;
                            mem_addr  <= req_addr;
                            mem_wdata <= '0;
                        end else begin
                            mem_req <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        resp_data <= mem_rdata;
                    end
                end
                RESPOND: begin
                    out_valid    <= 1'b1;
                    data_out     <= resp_data;
                    hit_miss_out <= sel_hit;
                end
                default: ;
            endcase
        end
    end

    // Line state and LRU ages, committed once per request in RESPOND
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    line_valid[SET_BITS'(s)][AGE_BITS'(w)] <= 1'b0;
                    line_dirty[SET_BITS'(s)][AGE_BITS'(w)] <= 1'b0;
                    line_tag[SET_BITS'(s)][AGE_BITS'(w)]   <= '0;
                    line_data[SET_BITS'(s)][AGE_BITS'(w)]  <= '0;
                    line_age[SET_BITS'(s)][AGE_BITS'(w)]   <= AGE_BITS'(w);
                end
            end
        end else if (state == RESPOND) begin
            case (req_op)
                OP_FLUSH: begin
                    if (sel_hit) begin
                        line_valid[req_set][sel_way] <= 1'b0;
                        line_dirty[req_set][sel_way] <= 1'b0;
                    end
                end
                OP_READ, OP_WRITE: begin
                    line_valid[req_set][sel_way] <= 1'b1;
                    line_tag[req_set][sel_way]   <= req_tag;
                    if (req_op == OP_WRITE) begin
                        line_data[req_set][sel_way]  <= req_wdata;
                        line_dirty[req_set][sel_way] <= 1'b1;
                    end else if (!sel_hit) begin
                        line_data[req_set][sel_way]  <= resp_data;
                        line_dirty[req_set][sel_way] <= 1'b0;
                    end
                    for (int unsigned w = 0; w < WAYS; w++) begin
                        if (line_age[req_set][AGE_BITS'(w)] < line_age[req_set][sel_way])
                            line_age[req_set][AGE_BITS'(w)] <= line_age[req_set][AGE_BITS'(w)] + 1'b1;
                    end
                    line_age[req_set][sel_way] <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
